// File: rtl/packet_parser.sv
`timescale 1ns/1ps
// Packet parser: fetches a header, N data bytes and a CRC-8 byte from inmem,
// copies the data bytes to outmem and flags a CRC mismatch on completion.
module packet_parser (
  input  logic        clk,
  input  logic        reset,
  input  logic        pp_start,
  input  logic [31:0] pp_addr_hdr,
  input  logic [31:0] pp_addr_out,
  output logic        pp_busy,
  output logic        pp_irq,
  output logic        pp_crc_err,
  output logic [4:0]  pp_byte_cnt_o,
  output logic [31:0] inmem_addr,
  input  logic [31:0] inmem_data_i,
  output logic [31:0] outmem_addr,
  output logic [31:0] outmem_data_o,
  output logic [3:0]  outmem_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_RD, S_HDR_LAT, S_DATA, S_CRC_RD, S_CRC_CHK, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_hdr;
  logic [31:0] r_out;
  logic [3:0]  r_idx;
  logic [7:0]  r_crc;
  logic [1:0]  r_rd_lane;
  logic        r_busy;
  logic        r_irq;
  logic        r_crc_err;
  logic [4:0]  r_byte_cnt;

  logic [7:0]  w_byte;
  logic        w_last;
  logic [7:0]  w_crc_next;
  logic [31:0] w_out_addr;

  // One CRC-8 step (poly 0x07, MSB first) over a full byte
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Byte lane selected by the address issued in the previous cycle
  assign w_byte     = inmem_data_i[{r_rd_lane, 3'b000} +: 8];
  assign w_last     = ({1'b0, r_idx} == (r_byte_cnt - 5'd1));
  assign w_crc_next = crc8_step(r_crc, w_byte);
  assign w_out_addr = r_out + 32'(r_idx);

  assign pp_busy       = r_busy;
  assign pp_irq        = r_irq;
  assign pp_crc_err    = r_crc_err;
  assign pp_byte_cnt_o = r_byte_cnt;

  // Memory-side outputs follow the state; writes forward the byte arriving this cycle
  always_comb begin
    inmem_addr    = '0;
    outmem_addr   = '0;
    outmem_data_o = '0;
    outmem_we     = '0;
    case (r_state)
      S_HDR_RD:  inmem_addr = r_hdr;
      S_HDR_LAT: inmem_addr = r_hdr + 32'd2;
      S_DATA: begin
        if (!w_last) inmem_addr = r_hdr + 32'(r_idx) + 32'd3;
        outmem_addr   = w_out_addr;
        outmem_data_o = {4{w_byte}};
        outmem_we     = 4'b0001 << w_out_addr[1:0];
      end
      S_CRC_RD:  inmem_addr = r_hdr + 32'(r_byte_cnt) + 32'd2;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hdr      <= '0;
      r_out      <= '0;
      r_idx      <= '0;
      r_crc      <= '0;
      r_rd_lane  <= '0;
      r_busy     <= 1'b0;
      r_irq      <= 1'b0;
      r_crc_err  <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_rd_lane <= inmem_addr[1:0];
      r_irq     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pp_start) begin
            r_hdr     <= pp_addr_hdr;
            r_out     <= pp_addr_out;
            r_crc_err <= 1'b0;
            r_crc     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_HDR_RD;
          end
        end
        S_HDR_RD: r_state <= S_HDR_LAT;
        S_HDR_LAT: begin
          r_byte_cnt <= 5'(w_byte[3:0]) + 5'd1;
          r_idx      <= '0;
          r_state    <= S_DATA;
        end
        S_DATA: begin
          r_crc <= w_crc_next;
          if (w_last) r_state <= S_CRC_RD;
          else        r_idx   <= r_idx + 4'd1;
        end
        S_CRC_RD: r_state <= S_CRC_CHK;
        S_CRC_CHK: begin
          r_crc_err <= (w_byte != r_crc);
          r_irq     <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
